// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Optional even-parity framing is enabled with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  wr_next;
    logic [ADDR_W:0]  rd_next;
    logic             do_push;
    logic             do_pop;

    // A push while full still lands when the same cycle frees the head slot.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_next = wr_ptr + {{ADDR_W{1'b0}}, do_push};
        rd_next = rd_ptr + {{ADDR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            full   <= (wr_next[ADDR_W] != rd_next[ADDR_W]) &&
                      (wr_next[ADDR_W-1:0] == rd_next[ADDR_W-1:0]);
            empty  <= (wr_next == rd_next);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter producing 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// All line-side outputs come straight from registers.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DEPTH       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned BAUD_W     = $clog2(BIT_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    tx_state_e            state;
    logic [BAUD_W-1:0]    baud;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign bit_end = (baud == '0);
    // Popping on the last stop cycle lets the next start bit follow with no idle gap.
    assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                state   <= START;
                baud    <= BAUD_LAST;
                shift   <= head;
                tx      <= 1'b0;
                tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^head;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            baud    <= BAUD_LAST;
                            tx      <= shift[0];
                        end else begin
                            baud <= baud - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud <= BAUD_LAST;
                            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= parity_bit;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shift   <= shift >> 1;
                                tx      <= shift[1];
                            end
                        end else begin
                            baud <= baud - 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state <= STOP;
                            baud  <= BAUD_LAST;
                            tx    <= 1'b1;
                        end else begin
                            baud <= baud - 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end else begin
                            baud    <= baud - 1'b1;
                            tx_done <= (baud == BAUD_W'(1));
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame table, burst/overflow, random traffic, reset mid-frame.
// Runs with a short bit period; the frame model follows UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int BC    = 12;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic       full, empty, tx, tx_busy, tx_done;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ(1_200_000),
        .BAUD_RATE  (100_000),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .full     (full),
        .empty    (empty),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: byte queue plus a frame timeline counted from each pop.
    logic [7:0]  q[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  dropped[$];
    logic [7:0]  rx_q[$];
    int          t = -1;
    logic [10:0] frame = '0;
    int          done_cnt = 0;
    int          rst_cnt = 0;

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit pop_m;
        bit acc;
        if (!reset) begin
            q.delete();
            t = -1;
        end else begin
            pop_m = (q.size() != 0) && (t < 0 || t == FRAME - 1);
            acc   = push && (q.size() < DEPTH || pop_m);
            if (pop_m) begin
                frame = mk_frame(q.pop_front());
                t = 0;
            end else if (t >= 0) begin
                t = (t == FRAME - 1) ? -1 : t + 1;
            end
            if (acc) begin
                q.push_back(push_data);
                acc_q.push_back(push_data);
            end else if (push) begin
                dropped.push_back(push_data);
            end
        end
    end

    always @(negedge clk) begin : cycle_check
        logic [4:0] exp_v;
        exp_v = {(t < 0) ? 1'b1 : frame[t / BC], t >= 0, t == FRAME - 1,
                 q.size() == DEPTH, q.size() == 0};
        check("cycle", {27'd0, tx, tx_busy, tx_done, full, empty}, {27'd0, exp_v});
        if (tx_done === 1'b1) done_cnt++;
    end

    always @(negedge reset) rst_cnt++;

    // Line receiver: samples mid-bit, discards frames cut short by reset.
    always begin : rx_model
        logic [7:0] d;
        int r0;
        @(negedge clk);
        if (reset === 1'b1 && tx === 1'b0) begin
            r0 = rst_cnt;
            d  = '0;
            repeat (BC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BC) @(negedge clk);
                d[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (BC) @(negedge clk);
            if (rst_cnt == r0) check("rx_parity", {31'd0, tx}, {31'd0, ^d});
`endif
            repeat (BC) @(negedge clk);
            if (rst_cnt == r0) begin
                check("rx_stop", {31'd0, tx}, 32'd1);
                rx_q.push_back(d);
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(q.size() == 0 && t < 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", (q.size() == 0 && t < 0) ? {31'd0, tx_busy} : 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        int d0;
        logic [10:0] got;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hAA, 11'h554};
        vecs[1] = '{8'h00, 11'h400};
        vecs[2] = '{8'hFF, 11'h5FE};
        vecs[3] = '{8'hA5, 11'h54A};
        vecs[4] = '{8'h3C, 11'h478};
        vecs[5] = '{8'h07, 11'h60E};
        vecs[6] = '{8'h03, 11'h406};
`else
        vecs[0] = '{8'hAA, 11'h354};
        vecs[1] = '{8'h00, 11'h200};
        vecs[2] = '{8'hFF, 11'h3FE};
        vecs[3] = '{8'hA5, 11'h34A};
        vecs[4] = '{8'h3C, 11'h278};
        vecs[5] = '{8'h07, 11'h20E};
        vecs[6] = '{8'h03, 11'h206};
`endif

        repeat (2) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single frames from the table, with push-to-start latency.
        for (int i = 0; i < 7; i++) begin
            wait_idle(4 * FRAME);
            d0 = done_cnt;
            push = 1'b1;
            push_data = vecs[i].data;
            @(negedge clk);
            push = 1'b0;
            check("lat_edge_n", {31'd0, tx}, 32'd1);
            @(negedge clk);
            check("lat_edge_n1", {31'd0, tx}, 32'd0);
            got = '0;
            repeat (BC / 2) @(negedge clk);
            for (int s = 0; s < NB; s++) begin
                got[s] = tx;
                repeat (BC) @(negedge clk);
            end
            check("line", {21'd0, got}, {21'd0, vecs[i].line});
            check("done_pulses", done_cnt - d0, 32'd1);
            check("busy_after", {31'd0, tx_busy}, 32'd0);
        end

        // Burst of 41 bytes: 0x00..0x10 accepted, 0x11..0x28 dropped.
        wait_idle(4 * FRAME);
        acc_q.delete();
        dropped.delete();
        rx_q.delete();
        for (int b = 0; b <= 8'h28; b++) begin
            push = 1'b1;
            push_data = 8'(b);
            @(negedge clk);
            if (b == 15) check("full_before_16", {31'd0, full}, 32'd0);
            if (b == 16) check("full_at_16", {31'd0, full}, 32'd1);
        end
        push = 1'b0;

        // Push on the cycle the full FIFO pops: both happen, nothing lost.
        n = 0;
        while (t != FRAME - 1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_seen", (n < 4 * FRAME) ? 32'd1 : 32'd0, 32'd1);
        check("full_before_pp", {31'd0, full}, 32'd1);
        push = 1'b1;
        push_data = 8'h77;
        @(negedge clk);
        push = 1'b0;
        check("full_after_pp", {31'd0, full}, 32'd1);
        wait_idle(20 * FRAME);
        check("dropped_count", dropped.size(), 32'd24);
        if (dropped.size() == 24) begin
            check("dropped_first", {24'd0, dropped[0]}, 32'h11);
            check("dropped_last", {24'd0, dropped[23]}, 32'h28);
        end
        check("burst_rx_count", rx_q.size(), 32'd18);
        for (int k = 0; k < 18 && k < rx_q.size(); k++) begin
            check("burst_rx_order", {24'd0, rx_q[k]}, (k == 17) ? 32'h77 : k);
        end

        // Random traffic: light load, then heavy load with overflow.
        acc_q.delete();
        rx_q.delete();
        for (int c = 0; c < 1600; c++) begin
            push = ($urandom_range(0, (c < 800) ? 39 : 3) == 0);
            push_data = 8'($urandom);
            @(negedge clk);
        end
        push = 1'b0;
        wait_idle(20 * FRAME);
        check("rand_rx_count", rx_q.size(), acc_q.size());
        for (int k = 0; k < rx_q.size() && k < acc_q.size(); k++) begin
            check("rand_rx_data", {24'd0, rx_q[k]}, {24'd0, acc_q[k]});
        end

        // Reset during data bit 3 of 0x5C.
        wait_idle(4 * FRAME);
        d0 = done_cnt;
        push = 1'b1;
        push_data = 8'h5C;
        @(negedge clk);
        push = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_start_seen", {31'd0, tx}, 32'd0);
        repeat (BC / 2 + 4 * BC) @(negedge clk);
        check("rst_mid_bit3", {31'd0, tx}, 32'd1);
        check("rst_mid_busy", {31'd0, tx_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_empty", {31'd0, empty}, 32'd1);
        check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("async_rst_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        check("idle_after_rst", n, 32'd0);
        check("no_done_after_rst", done_cnt - d0, 32'd0);
        check("empty_after_rst", {31'd0, empty}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
